// File: rtl/ram_arb.sv
// Two-port round-robin arbiter in front of a single-port RAM with 1-cycle read latency.
// One transaction in flight; the grant cycle drives the RAM directly, RESP holds the result.
module ram_arb #(
  parameter int DW = 128,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_wen,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_resp_valid,
  input  logic          p0_resp_ready,
  output logic [DW-1:0] p0_resp_rdata,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_wen,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_resp_valid,
  input  logic          p1_resp_ready,
  output logic [DW-1:0] p1_resp_rdata,
  output logic          ram_ren,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid & ready are both high; ready never depends on resp_ready.

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t          state, state_nx;
  logic            owner, is_wr, prio;
  logic            any_valid, grant;
  logic            sel_wen;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            owner_resp_ready;
  logic [DW-1:0]   resp_data;

  assign any_valid        = p0_req_valid | p1_req_valid;
  assign grant            = (p0_req_valid & p1_req_valid) ? prio : p1_req_valid;
  assign owner_resp_ready = owner ? p1_resp_ready : p0_resp_ready;
  assign resp_data        = is_wr ? '0 : ram_rdata;
  assign dbg_state        = state;

  always_comb begin
    sel_wen   = p0_req_wen;
    sel_addr  = p0_req_addr;
    sel_wdata = p0_req_wdata;
    if (grant) begin
      sel_wen   = p1_req_wen;
      sel_addr  = p1_req_addr;
      sel_wdata = p1_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      is_wr <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_valid) begin
        owner <= grant;
        is_wr <= sel_wen;
        prio  <= ~grant;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_valid) state_nx = RESP;
      RESP:    if (owner_resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are gated by rst_n so they fall immediately when reset asserts.
  always_comb begin
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    p0_resp_rdata = '0;
    p1_resp_rdata = '0;
    ram_ren       = 1'b0;
    ram_wen       = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            p0_req_ready = ~grant;
            p1_req_ready = grant;
            ram_ren      = ~sel_wen;
            ram_wen      = sel_wen;
            ram_addr     = sel_addr;
            ram_wdata    = sel_wdata;
          end
        end
        RESP: begin
          if (owner) begin
            p1_resp_valid = 1'b1;
            p1_resp_rdata = resp_data;
          end else begin
            p0_resp_valid = 1'b1;
            p0_resp_rdata = resp_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb with a behavioural single-port RAM attached.
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
module tb_ram_arb;
  localparam int DW = 128;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req_valid, p0_req_ready, p0_req_wen;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata;
  logic          p0_resp_valid, p0_resp_ready;
  logic [DW-1:0] p0_resp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_wen;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata;
  logic          p1_resp_valid, p1_resp_ready;
  logic [DW-1:0] p1_resp_rdata;
  logic          ram_ren, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          dbg_state;

  logic [DW-1:0] mem [0:255];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [DW-1:0] WR_DATA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] D01 = 128'h1111_0001;
  localparam logic [DW-1:0] D02 = 128'h2222_0002;
  localparam logic [DW-1:0] D10 = 128'hA5A5_0010;
  localparam logic [DW-1:0] D11 = 128'hA5A5_0011;
  localparam logic [DW-1:0] D12 = 128'hA5A5_0012;
  localparam logic [DW-1:0] D13 = 128'hA5A5_0013;

  always #5 clk = ~clk;

  ram_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_wen(p0_req_wen),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_wen(p1_req_wen),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // Behavioural RAM: registered read, 1-cycle latency.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr[7:0]] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_addr[7:0]];
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h01] = D01;
    mem[8'h02] = D02;
    mem[8'h10] = D10;
    mem[8'h11] = D11;
    mem[8'h12] = D12;
    mem[8'h13] = D13;

    // Reset with both requests valid: every output low.
    rst_n = 1'b0;
    p0_req_valid = 1'b1; p0_req_wen = 1'b0; p0_req_addr = 16'h0001; p0_req_wdata = '1;
    p1_req_valid = 1'b1; p1_req_wen = 1'b0; p1_req_addr = 16'h0010; p1_req_wdata = '1;
    p0_resp_ready = 1'b1; p1_resp_ready = 1'b1;
    #2;
    check("rst_p0_req_ready", p0_req_ready, 0);
    check("rst_p1_req_ready", p1_req_ready, 0);
    check("rst_p0_resp_valid", p0_resp_valid, 0);
    check("rst_p1_resp_valid", p1_resp_valid, 0);
    check("rst_ram_ren", ram_ren, 0);
    check("rst_ram_wen", ram_wen, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_p0_resp_rdata", p0_resp_rdata, 0);
    check("rst_p1_resp_rdata", p1_resp_rdata, 0);
    check("rst_state", dbg_state, 0);

    // Release with only port 1 reading 0x0010.
    tick();
    rst_n = 1'b1; p0_req_valid = 1'b0;
    #1;
    check("rel_p1_req_ready", p1_req_ready, 1);
    check("rel_p0_req_ready", p0_req_ready, 0);
    check("rel_ram_ren", ram_ren, 1);
    check("rel_ram_addr", ram_addr, 16'h0010);
    tick();
    p1_req_valid = 1'b0;
    #1;
    check("rel_p1_resp_valid", p1_resp_valid, 1);
    check("rel_p1_resp_rdata", p1_resp_rdata, D10);
    check("rel_state_resp", dbg_state, 1);

    // Port 0 write then read of 0x0005.
    tick();
    p0_req_valid = 1'b1; p0_req_wen = 1'b1; p0_req_addr = 16'h0005; p0_req_wdata = WR_DATA;
    #1;
    check("wr_p0_req_ready", p0_req_ready, 1);
    check("wr_ram_wen", ram_wen, 1);
    check("wr_ram_ren", ram_ren, 0);
    check("wr_ram_addr", ram_addr, 16'h0005);
    check("wr_ram_wdata", ram_wdata, WR_DATA);
    tick();
    p0_req_valid = 1'b0;
    #1;
    check("wr_resp_valid", p0_resp_valid, 1);
    check("wr_resp_rdata", p0_resp_rdata, 0);
    check("wr_resp_ram_wen", ram_wen, 0);
    tick();
    p0_req_valid = 1'b1; p0_req_wen = 1'b0; p0_req_addr = 16'h0005; p0_req_wdata = '0;
    #1;
    check("rd_p0_req_ready", p0_req_ready, 1);
    check("rd_ram_ren", ram_ren, 1);
    tick();
    p0_req_valid = 1'b0;
    #1;
    check("rd_resp_valid", p0_resp_valid, 1);
    check("rd_resp_rdata", p0_resp_rdata, WR_DATA);
    check("rd_p1_resp_rdata", p1_resp_rdata, 0);

    // Fresh reset, then both ports continuously valid: grants 0,1,0,1.
    tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    p0_req_valid = 1'b1; p0_req_wen = 1'b0; p0_req_addr = 16'h0001;
    p1_req_valid = 1'b1; p1_req_wen = 1'b0; p1_req_addr = 16'h0002;
    for (int g = 0; g < 4; g++) begin
      #1;
      check("tie_p0_req_ready", p0_req_ready, (g % 2 == 0));
      check("tie_p1_req_ready", p1_req_ready, (g % 2 == 1));
      check("tie_ram_ren", ram_ren, 1);
      check("tie_ram_addr", ram_addr, (g % 2 == 0) ? 16'h0001 : 16'h0002);
      tick();
      #1;
      check("tie_resp_ram_ren", ram_ren, 0);
      check("tie_resp_req_ready", {p0_req_ready, p1_req_ready}, 0);
      check("tie_p0_resp_valid", p0_resp_valid, (g % 2 == 0));
      check("tie_p1_resp_valid", p1_resp_valid, (g % 2 == 1));
      check("tie_resp_rdata", (g % 2 == 0) ? p0_resp_rdata : p1_resp_rdata, (g % 2 == 0) ? D01 : D02);
      tick();
      #0;
    end

    // Response backpressure on a port 1 read of 0x0002 while port 0 waits.
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b1; p1_req_addr = 16'h0002;
    #1;
    check("bp_p1_req_ready", p1_req_ready, 1);
    tick();
    p1_req_valid = 1'b0; p1_resp_ready = 1'b0;
    p0_req_valid = 1'b1; p0_req_addr = 16'h0001; p0_resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_p1_resp_valid", p1_resp_valid, 1);
      check("bp_p1_resp_rdata", p1_resp_rdata, D02);
      check("bp_p0_req_ready", p0_req_ready, 0);
      check("bp_ram_ren", ram_ren, 0);
      tick();
    end
    p1_resp_ready = 1'b1;
    #1;
    check("bp_release_p0_req_ready", p0_req_ready, 0);
    tick();
    #1;
    check("bp_after_p0_req_ready", p0_req_ready, 1);
    check("bp_after_p1_resp_valid", p1_resp_valid, 0);
    tick();
    p0_req_valid = 1'b0;

    // Asynchronous reset while port 0's read response is pending.
    #1;
    check("mid_p0_resp_valid", p0_resp_valid, 1);
    check("mid_p0_resp_rdata", p0_resp_rdata, D01);
    rst_n = 1'b0;
    #1;
    check("mid_rst_p0_resp_valid", p0_resp_valid, 0);
    check("mid_rst_p0_resp_rdata", p0_resp_rdata, 0);
    tick();
    rst_n = 1'b1;
    p0_resp_ready = 1'b1;
    p0_req_valid = 1'b1; p0_req_addr = 16'h0001;
    p1_req_valid = 1'b1; p1_req_addr = 16'h0002;
    #1;
    check("mid_tie_p0_req_ready", p0_req_ready, 1);
    check("mid_tie_p1_req_ready", p1_req_ready, 0);
    tick();
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    #1;
    check("mid_tie_p0_resp_valid", p0_resp_valid, 1);
    tick();

    // Port 1 streams four reads; port 0 stays silent.
    for (int r = 0; r < 4; r++) begin
      logic [AW-1:0] a;
      a = 16'h0010 + 16'(r);
      p1_req_valid = 1'b1; p1_req_addr = a;
      #1;
      check("st_p1_req_ready", p1_req_ready, 1);
      check("st_p0_req_ready", p0_req_ready, 0);
      check("st_ram_addr", ram_addr, a);
      tick();
      #1;
      check("st_p1_resp_valid", p1_resp_valid, 1);
      check("st_p1_req_ready_resp", p1_req_ready, 0);
      check("st_p0_resp_valid", p0_resp_valid, 0);
      check("st_p1_resp_rdata", p1_resp_rdata, mem[a[7:0]]);
      tick();
    end
    p1_req_valid = 1'b0;
    #1;
    check("end_idle_ram_ren", ram_ren, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
# ram_arb

Two-port round-robin arbiter and sequencer in front of the single-port simulation `ram` (DW-bit line, AW-bit line address, registered read with 1-cycle latency). It lets two requesters share the RAM, typically instruction fetch on port 0 and load/store on port 1. Each requester talks through a valid/ready request channel and a valid/ready response channel. One transaction is in flight at a time, and the block drives the RAM's `ren`/`wen`/`addr`/`wdata` and returns its `rdata` to the owning requester.

## Interface
- `DW`, 128, data width in bits; must match the attached `ram`.
- `AW`, 16, line address width; must match the attached `ram`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pN_req_valid`  in  1  port N (N=0,1) request present.
- `pN_req_ready`  out  1  port N request accepted this cycle.
- `pN_req_wen`  in  1  1 = write, 0 = read.
- `pN_req_addr`  in  AW  line address.
- `pN_req_wdata`  in  DW  write data.
- `pN_resp_valid`  out  1  port N response present.
- `pN_resp_ready`  in  1  port N consumes response.
- `pN_resp_rdata`  out  DW  read data; all zeros for write responses.
- `ram_ren`  out  1  to `ram.ren`.
- `ram_wen`  out  1  to `ram.wen`.
- `ram_addr`  out  AW  to `ram.addr`.
- `ram_wdata`  out  DW  to `ram.wdata`.
- `ram_rdata`  in  DW  from `ram.rdata`.

## Operation
- **State machine states:** `IDLE` and `RESP`. State registers: `owner` (1 bit), `is_wr` (1 bit), `prio` (1 bit, the port favoured on a tie).

- **IDLE**
  - Grant selection:
    - Exactly one `pN_req_valid` high: grant = that port.
    - Both high: grant = `prio`.
    - Neither high: no grant, and all `ram_*` controls are low.
  - The granted port sees `pN_req_ready`=1, combinationally in the same cycle. The other port sees 0.
  - In the grant cycle the granted request drives the RAM directly:
    - `ram_addr` = `req_addr`.
    - `ram_wdata` = `req_wdata`.
    - `ram_ren` = !`req_wen`.
    - `ram_wen` = `req_wen`.
  - On that clock edge: `owner` ← grant, `is_wr` ← `req_wen`, `prio` ← !grant, state → `RESP`.

- **RESP**
  - `p[owner]_resp_valid` = 1. The other port's `resp_valid` = 0.
  - `p[owner]_resp_rdata` = `is_wr` ? 0 : `ram_rdata`.
    - `ram_rdata` stays stable because `ram_ren` is held low throughout `RESP`.
  - All `pN_req_ready` = 0, `ram_ren` = 0, `ram_wen` = 0.
  - When `p[owner]_resp_ready`=1: state → `IDLE` on that edge.
  - Otherwise the block stays in `RESP` indefinitely. The response is held and no new request is accepted.

- **Requester obligations:** once `pN_req_valid` is raised, the requester holds it and all request fields stable until `pN_req_ready`. The block does not check this.

- **Ports without a grant:** `pN_resp_rdata` = 0.

- **Fairness:** a port that just won loses the next tie. With both ports continuously valid, grants alternate 0,1,0,1…

- **Reset (`rst_n` low, asynchronous):**
  - state = `IDLE`, `prio` = 0, `owner` = 0, `is_wr` = 0.
  - All outputs go low immediately: `req_ready`, `resp_valid`, `ram_ren`, `ram_wen`, `ram_addr`, `ram_wdata`, `resp_rdata`.
  - An in-flight transaction is dropped and no response is produced.
  - A write issued in the same cycle that reset asserts may or may not land in the RAM.

## Timing
- **Request handshake** in cycle T (`valid & ready`): RAM access happens at edge T.
- **Response:** `resp_valid` = 1 from cycle T+1. Read data is valid in T+1, which is the 1-cycle RAM read latency.
- **Response handshake** in cycle T+k (k ≥ 1). The earliest next grant, for either port, is T+k+1.
- **Peak throughput:** one transaction per 2 cycles.
- **Combinational paths:**
  - `pN_req_ready` depends on state, `prio` and both `req_valid`.
  - `ram_*` depends on state, grant and request fields.
  - Neither path depends on `resp_ready`.
- **No bypass:** a request raised in the cycle a response completes is not granted in that cycle.

## Test plan
- **Reset values:** hold `rst_n`=0 with both `req_valid`=1.
  - Required: all outputs 0.
  - Release reset with only `p1_req_valid`=1, read at addr 0x0010. Required: `p1_req_ready`=1 in the first cycle and `ram_ren`=1 with `ram_addr`=0x0010.
- **Write then read:** port 0 writes 0x0123…CDEF to addr 0x0005, then reads 0x0005.
  - Required: write response `resp_valid` one cycle after the handshake, with `resp_rdata`=0.
  - Required: read response `resp_rdata`=0x0123…CDEF one cycle after its handshake.
- **Tie alternation:** both ports continuously valid (reads at 0x0001 and 0x0002), `resp_ready` tied to 1.
  - Required grant order after reset: 0,1,0,1. Each grant 2 cycles apart.
  - Required: no `ram_ren` in `RESP` cycles.
- **Response backpressure:** port 1 read of 0x0002; hold `p1_resp_ready`=0 for 5 cycles while `p0_req_valid`=1.
  - Required: `p1_resp_valid` and `p1_resp_rdata` stay stable throughout.
  - Required: `p0_req_ready` stays 0 until the cycle after `p1_resp_ready` is raised.
- **Mid-operation reset:** assert `rst_n`=0 asynchronously while in `RESP` for a port 0 read.
  - Required: `p0_resp_valid` drops without waiting for a clock edge.
  - After release, `prio`=0. Required: a tie grants port 0.
- **Single-requester streaming:** only port 1 issues 4 back-to-back reads with `resp_ready`=1.
  - Required: grants every 2 cycles. Port 0 never sees `req_ready` or `resp_valid`.
